// File: rtl/matrix_memory_bank.sv
// Matrix word store: DEPTH words of DIM x DIM elements, masked writes, registered reads,
// post-reset clear sweep. Define MATMEM_TRANSPOSE_EN to enable transposed reads (mode 1).
module matrix_memory_bank #(
  parameter int unsigned ELEM_W    = 16,
  parameter int unsigned DIM       = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter logic [3:0]  ENABLE_ID = 4'h1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIM*DIM*ELEM_W-1:0] inputBus,
  input  logic [ADDR_W-1:0]         addressBus,
  input  logic                      writeToMem,
  input  logic                      readFromMem,
  input  logic [DIM*DIM-1:0]        elemMask,
  output logic [DIM*DIM*ELEM_W-1:0] dataBus,
  output logic                      dataValid,
  output logic                      busy,
  output logic                      cmdError
);

  localparam int unsigned NELEM  = DIM * DIM;
  localparam int unsigned WORD_W = NELEM * ELEM_W;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StClear, StIdle, StReadOut} state_e;

  state_e             r_state, w_state_next;
  logic [PTR_W-1:0]   r_clr_ptr, w_clr_ptr_next;
  logic [WORD_W-1:0]  r_mem [DEPTH];
  logic [WORD_W-1:0]  r_rd_data;
  logic               r_valid;
  logic               r_err;

  logic               w_sel, w_idx_ok, w_mode_ok, w_bad, w_go;
  logic               w_accept_wr, w_accept_rd, w_reject;
  logic [7:0]         w_idx;
  logic [3:0]         w_mode;
  logic [PTR_W-1:0]   w_addr;
  logic [WORD_W-1:0]  w_mem_word, w_rd_word;

  assign w_sel    = (addressBus[ADDR_W-1 -: 4] == ENABLE_ID);
  assign w_idx    = addressBus[11:4];
  assign w_mode   = addressBus[3:0];
  assign w_addr   = PTR_W'(w_idx);
  assign w_idx_ok = (32'(w_idx) < DEPTH);

`ifdef MATMEM_TRANSPOSE_EN
  assign w_mode_ok = (w_mode == 4'd0) || (w_mode == 4'd1);
`else
  assign w_mode_ok = (w_mode == 4'd0);
`endif

  assign w_bad       = (writeToMem & readFromMem) | ~w_idx_ok | ~w_mode_ok;
  assign w_go        = w_sel & (writeToMem | readFromMem) & (r_state != StClear);
  assign w_accept_wr = w_go & ~w_bad & writeToMem;
  assign w_accept_rd = w_go & ~w_bad & readFromMem;
  assign w_reject    = w_go & w_bad;

  assign w_mem_word = r_mem[w_addr];

  always_comb begin
    w_rd_word = w_mem_word;
`ifdef MATMEM_TRANSPOSE_EN
    if (w_mode[0]) begin
      for (int unsigned r = 0; r < DIM; r++) begin
        for (int unsigned c = 0; c < DIM; c++) begin
          w_rd_word[(r*DIM+c)*ELEM_W +: ELEM_W] = w_mem_word[(c*DIM+r)*ELEM_W +: ELEM_W];
        end
      end
    end
`endif
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_ptr_next = r_clr_ptr;
    unique case (r_state)
      StClear: begin
        w_clr_ptr_next = r_clr_ptr + 1'b1;
        if (r_clr_ptr == PTR_W'(DEPTH - 1)) begin
          w_state_next   = StIdle;
          w_clr_ptr_next = '0;
        end
      end
      StIdle, StReadOut: w_state_next = w_accept_rd ? StReadOut : StIdle;
      default:           w_state_next = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= StClear;
      r_clr_ptr <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_ptr <= w_clr_ptr_next;
      r_valid   <= w_accept_rd;
      r_err     <= w_reject;
      if (w_accept_rd) r_rd_data <= w_rd_word;
    end
  end

  // Storage has no reset of its own; the sweep zeroes it once reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (r_state == StClear) begin
        r_mem[r_clr_ptr] <= '0;
      end else if (w_accept_wr) begin
        for (int unsigned k = 0; k < NELEM; k++) begin
          if (elemMask[k]) r_mem[w_addr][k*ELEM_W +: ELEM_W] <= inputBus[k*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  assign dataBus   = r_valid ? r_rd_data : 'z;
  assign dataValid = r_valid;
  assign busy      = (r_state == StClear);
  assign cmdError  = r_err;

endmodule

// File: tb/tb_matrix_memory_bank.sv
// Self-checking bench for matrix_memory_bank: table-driven request vectors with a response
// scoreboard, plus hand-written reset/clear-sweep sequences.
module tb_matrix_memory_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] inputBus;
  logic [15:0]  addressBus;
  logic         writeToMem;
  logic         readFromMem;
  logic [15:0]  elemMask;
  wire  [255:0] dataBus;
  logic         dataValid;
  logic         busy;
  logic         cmdError;

  always #5 clk = ~clk;

  matrix_memory_bank dut (
    .clk        (clk),
    .reset      (reset),
    .inputBus   (inputBus),
    .addressBus (addressBus),
    .writeToMem (writeToMem),
    .readFromMem(readFromMem),
    .elemMask   (elemMask),
    .dataBus    (dataBus),
    .dataValid  (dataValid),
    .busy       (busy),
    .cmdError   (cmdError)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         valid;
    logic         err;
    logic [255:0] data;
  } exp_t;

  typedef struct {
    logic [15:0]  addr;
    logic         wr;
    logic         rd;
    logic [15:0]  mask;
    logic [255:0] data;
    logic         exp_valid;
    logic         exp_err;
    logic [255:0] exp_data;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic w, input logic r,
                       input logic [15:0] m, input logic [255:0] d);
    addressBus  = a;
    writeToMem  = w;
    readFromMem = r;
    elemMask    = m;
    inputBus    = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pat(input logic [15:0] base, input logic [15:0] step);
    logic [255:0] w;
    for (int k = 0; k < 16; k++) w[k*16 +: 16] = base + step * 16'(k);
    return w;
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] nw,
                                         input logic [15:0] m);
    logic [255:0] w;
    for (int k = 0; k < 16; k++) w[k*16 +: 16] = m[k] ? nw[k*16 +: 16] : old[k*16 +: 16];
    return w;
  endfunction

  function automatic void add(input logic [15:0] a, input logic w, input logic r,
                              input logic [15:0] m, input logic [255:0] d,
                              input logic ev, input logic ee, input logic [255:0] ed);
    vec_t v;
    v.addr = a; v.wr = w; v.rd = r; v.mask = m; v.data = d;
    v.exp_valid = ev; v.exp_err = ee; v.exp_data = ed;
    vecs.push_back(v);
  endfunction

  // Clock-edge count during which busy stays high, starting with the current cycle.
  task automatic count_busy(output int n, output logic any_resp);
    logic done;
    n = busy ? 1 : 0;
    any_resp = dataValid | cmdError;
    done = !busy;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      any_resp = any_resp | dataValid | cmdError;
      if (busy) n++;
      else done = 1'b1;
    end
    if (!done) n = 99;
  endtask

  initial begin
    logic [255:0] zero, ones, a_w, b_w, b2_w, c_w, cm_w, asc_w, tasc_w, d_w;
    exp_t e;
    int   nb;
    logic resp;

    zero  = '0;
    ones  = '1;
    a_w   = pat(16'h0009, 16'h0013);
    b_w   = pat(16'h0003, 16'h0101);
    b2_w  = merge(b_w, ones, 16'h0001);
    c_w   = pat(16'hA5A0, 16'h0011);
    cm_w  = merge(zero, c_w, 16'hAAAA);
    asc_w = pat(16'h0000, 16'h0001);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) tasc_w[(r*4+c)*16 +: 16] = 16'(c*4 + r);
    d_w   = pat(16'h7000, 16'h0003);

    //   addr      wr    rd    mask       data   valid err   data
    add(16'h1000, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, zero);
    add(16'h1000, 1'b0, 1'b0, 16'h0000, zero,  1'b0, 1'b0, zero);
    add(16'h1020, 1'b1, 1'b0, 16'hFFFF, a_w,   1'b0, 1'b0, zero);
    add(16'h1020, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, a_w);
    add(16'h1020, 1'b0, 1'b0, 16'h0000, zero,  1'b0, 1'b0, zero);
    add(16'h1030, 1'b1, 1'b0, 16'hFFFF, b_w,   1'b0, 1'b0, zero);
    add(16'h1030, 1'b1, 1'b0, 16'h0001, ones,  1'b0, 1'b0, zero);
    add(16'h1030, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, b2_w);
    add(16'h1020, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, a_w);
    add(16'h1020, 1'b1, 1'b1, 16'hFFFF, ones,  1'b0, 1'b1, zero);
    add(16'h1100, 1'b0, 1'b1, 16'h0000, zero,  1'b0, 1'b1, zero);
    add(16'h1100, 1'b1, 1'b0, 16'hFFFF, ones,  1'b0, 1'b1, zero);
    add(16'h1020, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, a_w);
    add(16'h1040, 1'b1, 1'b0, 16'h0000, ones,  1'b0, 1'b0, zero);
    add(16'h1040, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, zero);
    add(16'h2020, 1'b1, 1'b0, 16'hFFFF, ones,  1'b0, 1'b0, zero);
    add(16'h2020, 1'b0, 1'b1, 16'h0000, zero,  1'b0, 1'b0, zero);
    add(16'h1020, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, a_w);
    add(16'h10F0, 1'b1, 1'b0, 16'hAAAA, c_w,   1'b0, 1'b0, zero);
    add(16'h10F0, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, cm_w);
    add(16'h1050, 1'b1, 1'b0, 16'hFFFF, asc_w, 1'b0, 1'b0, zero);
`ifdef MATMEM_TRANSPOSE_EN
    add(16'h1051, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, tasc_w);
`else
    add(16'h1051, 1'b0, 1'b1, 16'h0000, zero,  1'b0, 1'b1, zero);
`endif
    add(16'h1052, 1'b1, 1'b0, 16'hFFFF, ones,  1'b0, 1'b1, zero);
    add(16'h1050, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, asc_w);
`ifdef MATMEM_TRANSPOSE_EN
    add(16'h1061, 1'b1, 1'b0, 16'hFFFF, d_w,   1'b0, 1'b0, zero);
    add(16'h1060, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, d_w);
`else
    add(16'h1061, 1'b1, 1'b0, 16'hFFFF, d_w,   1'b0, 1'b1, zero);
    add(16'h1060, 1'b0, 1'b1, 16'h0000, zero,  1'b1, 1'b0, zero);
`endif

    // Reset for two cycles, then the clear sweep with a read held the whole time.
    reset = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, zero);
    tick();
    tick();
    check("reset busy", busy, 1'b1);
    check("reset dataValid", dataValid, 1'b0);
    check("reset cmdError", cmdError, 1'b0);
    reset = 1'b1;
    drive(16'h1000, 1'b0, 1'b1, 16'h0000, zero);
    count_busy(nb, resp);
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, zero);
    check("sweep busy cycles", nb, 16);
    check("no response while busy", resp, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].mask, vecs[i].data);
      e.valid = vecs[i].exp_valid;
      e.err   = vecs[i].exp_err;
      e.data  = vecs[i].exp_data;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d dataValid", i), dataValid, e.valid);
      check($sformatf("vec%0d cmdError", i), cmdError, e.err);
      if (e.valid) check($sformatf("vec%0d dataBus", i), dataBus, e.data);
    end
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, zero);
    tick();
    check("idle dataValid", dataValid, 1'b0);

    // Reset asserted while read data is on the bus drops the strobe at that edge.
    drive(16'h1020, 1'b0, 1'b1, 16'h0000, zero);
    tick();
    check("pre-reset read valid", dataValid, 1'b1);
    check("pre-reset read data", dataBus, a_w);
    reset = 1'b0;
    drive(16'h1020, 1'b0, 1'b1, 16'h0000, zero);
    tick();
    check("reset mid-read dataValid", dataValid, 1'b0);
    check("reset mid-read busy", busy, 1'b1);
    tick();
    check("read during reset dataValid", dataValid, 1'b0);

    // Interrupt the sweep partway: it must restart from word 0.
    reset = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, zero);
    repeat (5) tick();
    check("mid-sweep busy", busy, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    count_busy(nb, resp);
    check("restarted sweep busy cycles", nb, 16);

    drive(16'h1020, 1'b0, 1'b1, 16'h0000, zero);
    tick();
    check("cleared word valid", dataValid, 1'b1);
    check("cleared word data", dataBus, zero);
    drive(16'h10F0, 1'b0, 1'b1, 16'h0000, zero);
    tick();
    check("cleared last word data", dataBus, zero);
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, zero);
    tick();
    check("final dataValid", dataValid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
